// File: rtl/adma2_pkg.sv
// Shared encodings for the ADMA2 descriptor engine: FSM states, descriptor
// action codes, error-state codes and descriptor attribute bit positions.
package adma2_pkg;

    typedef enum logic [3:0] {
        ST_STOP = 4'b0001,
        ST_FDS  = 4'b0010,
        ST_CADR = 4'b0100,
        ST_TFR  = 4'b1000
    } state_t;

    localparam logic [1:0] ACT_NOP  = 2'b00;
    localparam logic [1:0] ACT_RSV  = 2'b01;
    localparam logic [1:0] ACT_TRAN = 2'b10;
    localparam logic [1:0] ACT_LINK = 2'b11;

    localparam logic [1:0] ERR_ST_STOP = 2'b00;
    localparam logic [1:0] ERR_ST_FDS  = 2'b01;
    localparam logic [1:0] ERR_ST_TFR  = 2'b11;

    localparam int BIT_VALID  = 0;
    localparam int BIT_END    = 1;
    localparam int BIT_INT    = 2;
    localparam int BIT_ACT_LO = 4;
    localparam int BIT_ACT_HI = 5;
    localparam int BIT_LEN_LO = 16;
    localparam int BIT_LEN_HI = 31;
    localparam int BIT_ADDR_LO = 32;

    // 32-bit addressing uses 64-bit descriptors, 64-bit addressing uses 96-bit ones.
    function automatic int desc_width(input int addr_w);
        return (addr_w == 64) ? 96 : 64;
    endfunction

endpackage

// File: rtl/adma2_chain_engine_if.sv
// Bus bundle between the ADMA2 engine (master) and the descriptor-memory /
// data-mover side (slave).
//
// Handshakes:
//   desc_req/desc_ack: desc_req rises with a stable desc_addr and stays high
//   until a single-cycle desc_ack; desc_data is valid in the ack cycle only.
//   xfer_req/xfer_done/xfer_err: xfer_req is held with stable dir/addr/len
//   until the slave pulses exactly one of xfer_done or xfer_err for one cycle.
interface adma2_chain_engine_if #(
    parameter int ADDR_W = 64
);
    import adma2_pkg::*;
    localparam int DESC_W = desc_width(ADDR_W);

    logic              desc_req;
    logic [ADDR_W-1:0] desc_addr;
    logic              desc_ack;
    logic [DESC_W-1:0] desc_data;
    logic              xfer_req;
    logic              xfer_dir;
    logic [ADDR_W-1:0] xfer_addr;
    logic [16:0]       xfer_len;
    logic              xfer_done;
    logic              xfer_err;

    modport master (
        output desc_req, desc_addr, xfer_req, xfer_dir, xfer_addr, xfer_len,
        input  desc_ack, desc_data, xfer_done, xfer_err
    );

    modport slave (
        input  desc_req, desc_addr, xfer_req, xfer_dir, xfer_addr, xfer_len,
        output desc_ack, desc_data, xfer_done, xfer_err
    );
endinterface

// File: rtl/adma2_desc_decode.sv
// Combinational split of a raw ADMA2 descriptor into its attribute fields.
module adma2_desc_decode
    import adma2_pkg::*;
#(
    parameter int ADDR_W = 64,
    localparam int DESC_W = desc_width(ADDR_W)
) (
    input  logic [DESC_W-1:0] desc_data,
    output logic              d_valid,
    output logic              d_end,
    output logic              d_int,
    output logic [1:0]        d_act,
    output logic [15:0]       d_len,
    output logic [ADDR_W-1:0] d_addr
);
    // Reserved attribute bits carry no meaning for the engine.
    logic unused_bits;
    assign unused_bits = ^{desc_data[BIT_LEN_LO-1:BIT_ACT_HI+1], desc_data[3]};

    assign d_valid = desc_data[BIT_VALID];
    assign d_end   = desc_data[BIT_END];
    assign d_int   = desc_data[BIT_INT];
    assign d_act   = desc_data[BIT_ACT_HI:BIT_ACT_LO];
    assign d_len   = desc_data[BIT_LEN_HI:BIT_LEN_LO];
    assign d_addr  = desc_data[DESC_W-1:BIT_ADDR_LO];
endmodule

// File: rtl/adma2_chain_engine.sv
// ADMA2 descriptor chain engine: fetches descriptors, follows LINKs, issues one
// data transfer per TRAN descriptor, pauses at block gaps and guards against
// descriptor loops that never reach a TRAN.
module adma2_chain_engine
    import adma2_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int MAX_CHAIN = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    init_addr,
    input  logic                 dir,
    input  logic                 stop_at_gap,
    input  logic                 continue_req,
    adma2_chain_engine_if.master bus,
    output logic [ADDR_W-1:0]    sys_adr,
    output logic                 busy,
    output logic                 paused,
    output logic                 dma_int,
    output logic                 xfer_complete,
    output logic                 gap_evt,
    output logic                 adma_err,
    output logic [1:0]           err_state,
    output state_t               dbg_state
);
    localparam int DESC_W = desc_width(ADDR_W);
    localparam int CNT_W  = $clog2(MAX_CHAIN + 1);
    localparam logic [ADDR_W-1:0] DESC_STEP = ADDR_W'(DESC_W / 8);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_CHAIN);

    state_t state_q, state_d;

    logic              dec_valid, dec_end, dec_int;
    logic [1:0]        dec_act;
    logic [15:0]       dec_len;
    logic [ADDR_W-1:0] dec_addr;

    logic              cur_valid, cur_end, cur_int;
    logic [1:0]        cur_act;
    logic [15:0]       cur_len;
    logic [ADDR_W-1:0] cur_addr;

    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W-1:0] sys_adr_d, xfer_addr_q, xfer_addr_d;
    logic [16:0]       xfer_len_q, xfer_len_d;
    logic              xfer_dir_q, xfer_dir_d;
    logic              desc_req_q, xfer_req_q;
    logic              paused_d, int_d, cmpl_d, gap_d, err_d;
    logic [1:0]        err_state_d;

    adma2_desc_decode #(.ADDR_W(ADDR_W)) u_decode (
        .desc_data (bus.desc_data),
        .d_valid   (dec_valid),
        .d_end     (dec_end),
        .d_int     (dec_int),
        .d_act     (dec_act),
        .d_len     (dec_len),
        .d_addr    (dec_addr)
    );

    assign bus.desc_req  = desc_req_q;
    assign bus.desc_addr = sys_adr;
    assign bus.xfer_req  = xfer_req_q;
    assign bus.xfer_dir  = xfer_dir_q;
    assign bus.xfer_addr = xfer_addr_q;
    assign bus.xfer_len  = xfer_len_q;
    assign dbg_state     = state_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_STOP;
        else        state_q <= state_d;
    end

    // Latch the decoded descriptor in the ack cycle; CADR acts on it next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_valid <= 1'b0;
            cur_end   <= 1'b0;
            cur_int   <= 1'b0;
            cur_act   <= ACT_NOP;
            cur_len   <= '0;
            cur_addr  <= '0;
        end else if (state_q == ST_FDS && bus.desc_ack) begin
            cur_valid <= dec_valid;
            cur_end   <= dec_end;
            cur_int   <= dec_int;
            cur_act   <= dec_act;
            cur_len   <= dec_len;
            cur_addr  <= dec_addr;
        end
    end

    // Next-state, counter and next-output computation.
    always_comb begin
        state_d     = state_q;
        sys_adr_d   = sys_adr;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + CNT_W'(1);
        xfer_dir_d  = xfer_dir_q;
        xfer_addr_d = xfer_addr_q;
        xfer_len_d  = xfer_len_q;
        paused_d    = paused;
        err_state_d = err_state;
        int_d       = 1'b0;
        cmpl_d      = 1'b0;
        gap_d       = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_STOP: begin
                // A fresh start takes precedence over resuming a paused chain.
                if (start) begin
                    sys_adr_d   = init_addr;
                    xfer_dir_d  = dir;
                    paused_d    = 1'b0;
                    err_state_d = ERR_ST_STOP;
                    cnt_d       = '0;
                    state_d     = ST_FDS;
                end else if (continue_req && paused) begin
                    paused_d = 1'b0;
                    state_d  = ST_FDS;
                end
            end
            ST_FDS: begin
                if (bus.desc_ack) state_d = ST_CADR;
            end
            ST_CADR: begin
                if (!cur_valid) begin
                    err_d       = 1'b1;
                    err_state_d = ERR_ST_FDS;
                    state_d     = ST_STOP;
                end else if (cur_act == ACT_TRAN) begin
                    xfer_addr_d = cur_addr;
                    xfer_len_d  = (cur_len == 16'd0) ? 17'h10000 : {1'b0, cur_len};
                    sys_adr_d   = sys_adr + DESC_STEP;
                    cnt_d       = '0;
                    state_d     = ST_TFR;
                end else begin
                    // NOP/RSV step to the next slot; LINK jumps. Only TRAN
                    // clears the counter, so a pure LINK/NOP loop trips it.
                    sys_adr_d = (cur_act == ACT_LINK) ? cur_addr : sys_adr + DESC_STEP;
                    cnt_d     = cnt_inc;
                    int_d     = cur_int;
                    if (cnt_inc == CNT_LIMIT) begin
                        err_d       = 1'b1;
                        err_state_d = ERR_ST_FDS;
                        state_d     = ST_STOP;
                    end else if (cur_end) begin
                        cmpl_d  = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_FDS;
                    end
                end
            end
            ST_TFR: begin
                if (bus.xfer_err) begin
                    err_d       = 1'b1;
                    err_state_d = ERR_ST_TFR;
                    state_d     = ST_STOP;
                end else if (bus.xfer_done) begin
                    int_d = cur_int;
                    if (cur_end) begin
                        cmpl_d  = 1'b1;
                        state_d = ST_STOP;
                    end else if (stop_at_gap) begin
                        gap_d    = 1'b1;
                        paused_d = 1'b1;
                        state_d  = ST_STOP;
                    end else begin
                        state_d = ST_FDS;
                    end
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Registered outputs; request levels follow the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_adr       <= '0;
            cnt_q         <= '0;
            xfer_dir_q    <= 1'b0;
            xfer_addr_q   <= '0;
            xfer_len_q    <= '0;
            desc_req_q    <= 1'b0;
            xfer_req_q    <= 1'b0;
            busy          <= 1'b0;
            paused        <= 1'b0;
            dma_int       <= 1'b0;
            xfer_complete <= 1'b0;
            gap_evt       <= 1'b0;
            adma_err      <= 1'b0;
            err_state     <= ERR_ST_STOP;
        end else begin
            sys_adr       <= sys_adr_d;
            cnt_q         <= cnt_d;
            xfer_dir_q    <= xfer_dir_d;
            xfer_addr_q   <= xfer_addr_d;
            xfer_len_q    <= xfer_len_d;
            desc_req_q    <= (state_d == ST_FDS);
            xfer_req_q    <= (state_d == ST_TFR);
            busy          <= (state_d != ST_STOP);
            paused        <= paused_d;
            dma_int       <= int_d;
            xfer_complete <= cmpl_d;
            gap_evt       <= gap_d;
            adma_err      <= err_d;
            err_state     <= err_state_d;
        end
    end
endmodule

// File: tb/tb_adma2_chain_engine.sv
// Directed bench for adma2_chain_engine (ADDR_W=64, 96-bit descriptors).
module tb_adma2_chain_engine;
    import adma2_pkg::*;

    localparam logic [2:0] EV_INT  = 3'd1;
    localparam logic [2:0] EV_CMPL = 3'd2;
    localparam logic [2:0] EV_GAP  = 3'd3;
    localparam logic [2:0] EV_ERR  = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, dir, stop_at_gap, continue_req;
    logic [63:0] init_addr;
    logic [63:0] sys_adr;
    logic        busy, paused, dma_int, xfer_complete, gap_evt, adma_err;
    logic [1:0]  err_state;
    state_t      dbg_state;

    adma2_chain_engine_if #(.ADDR_W(64)) bus();

    adma2_chain_engine #(.ADDR_W(64), .MAX_CHAIN(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .init_addr(init_addr), .dir(dir),
        .stop_at_gap(stop_at_gap), .continue_req(continue_req), .bus(bus),
        .sys_adr(sys_adr), .busy(busy), .paused(paused), .dma_int(dma_int),
        .xfer_complete(xfer_complete), .gap_evt(gap_evt), .adma_err(adma_err),
        .err_state(err_state), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard state
    logic [95:0] mem [logic [63:0]];
    logic [63:0] exp_fetch_q[$];
    logic [81:0] exp_xfer_q[$];
    logic [2:0]  exp_evt_q[$];
    logic [63:0] fetch_log[$];
    logic [1:0]  exp_err_g;
    logic [16:0] last_xfer_len;
    int checks = 0, errors = 0;
    int n_int, n_cmpl, n_gap, n_err, n_xfer;
    int xfer_count, err_xfer;
    bit chk_en, xfer_hold;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_evt(input string name, input logic [2:0] code);
        if (exp_evt_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: got event %0d expected none", name, code);
        end else begin
            chk(name, 96'(code), 96'(exp_evt_q.pop_front()));
        end
    endtask

    function automatic logic [95:0] mk_desc(input logic v, input logic e, input logic i,
                                            input logic [1:0] act, input logic [15:0] len,
                                            input logic [63:0] addr);
        return {addr, len, 10'b0, act, 1'b0, i, e, v};
    endfunction

    // Reference model: walk the descriptor table and list what must be observed.
    task automatic model_chain(input logic [63:0] base, input logic d, input int errx,
                               input logic [7:0] gap_mask);
        logic [63:0] a;
        logic [95:0] dsc;
        logic [15:0] ln;
        int cnt, nx, idx;
        a = base; cnt = 0; nx = 0; exp_err_g = 2'b00;
        for (int g = 0; g < 64; g++) begin
            exp_fetch_q.push_back(a);
            dsc = mem.exists(a) ? mem[a] : '0;
            if (!dsc[0]) begin
                exp_evt_q.push_back(EV_ERR); exp_err_g = 2'b01; return;
            end
            if (dsc[5:4] == 2'b10) begin
                ln = dsc[31:16];
                exp_xfer_q.push_back({d, dsc[95:32], (ln == 16'd0) ? 17'd65536 : {1'b0, ln}});
                a = a + 64'd12; cnt = 0; idx = nx; nx++;
                if (idx == errx) begin
                    exp_evt_q.push_back(EV_ERR); exp_err_g = 2'b11; return;
                end
                if (dsc[2]) exp_evt_q.push_back(EV_INT);
                if (dsc[1]) begin exp_evt_q.push_back(EV_CMPL); return; end
                if (idx < 8 && gap_mask[idx]) exp_evt_q.push_back(EV_GAP);
            end else begin
                a = (dsc[5:4] == 2'b11) ? dsc[95:32] : a + 64'd12;
                cnt++;
                if (dsc[2]) exp_evt_q.push_back(EV_INT);
                if (cnt == 16) begin
                    exp_evt_q.push_back(EV_ERR); exp_err_g = 2'b01; return;
                end
                if (dsc[1]) begin exp_evt_q.push_back(EV_CMPL); return; end
            end
        end
    endtask

    // Descriptor memory responder: ack after a rotating 0..2 cycle delay.
    initial begin : desc_resp
        int wait_cnt, ack_dly;
        wait_cnt = 0; ack_dly = 0;
        bus.desc_ack = 1'b0; bus.desc_data = '0;
        forever begin
            @(negedge clk);
            bus.desc_ack = 1'b0;
            if (!bus.desc_req) wait_cnt = 0;
            else if (wait_cnt < ack_dly) wait_cnt++;
            else begin
                bus.desc_ack  = 1'b1;
                bus.desc_data = mem.exists(bus.desc_addr) ? mem[bus.desc_addr] : '0;
                wait_cnt = 0;
                ack_dly  = (ack_dly == 2) ? 0 : ack_dly + 1;
            end
        end
    end

    // Data mover responder: done (or err on the selected transfer) after 3 cycles.
    initial begin : xfer_resp
        int xdly;
        bit served;
        xdly = 0; served = 0;
        bus.xfer_done = 1'b0; bus.xfer_err = 1'b0;
        forever begin
            @(negedge clk);
            bus.xfer_done = 1'b0; bus.xfer_err = 1'b0;
            if (!bus.xfer_req) begin xdly = 0; served = 0; end
            else if (!served && !xfer_hold) begin
                if (xdly < 3) xdly++;
                else begin
                    if (xfer_count == err_xfer) bus.xfer_err = 1'b1;
                    else bus.xfer_done = 1'b1;
                    xfer_count++; served = 1;
                end
            end
        end
    end

    // Compare process: new fetches, new transfers and event pulses against the model.
    initial begin : compare
        bit prev_dreq, prev_xreq;
        prev_dreq = 0; prev_xreq = 0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && chk_en) begin
                if (bus.desc_req && !prev_dreq) begin
                    fetch_log.push_back(bus.desc_addr);
                    if (exp_fetch_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL fetch_unexpected: got addr %0h expected no fetch", bus.desc_addr);
                    end else chk("fetch_addr", 96'(bus.desc_addr), 96'(exp_fetch_q.pop_front()));
                end
                if (bus.xfer_req && !prev_xreq) begin
                    n_xfer++; last_xfer_len = bus.xfer_len;
                    if (exp_xfer_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL xfer_unexpected: got addr %0h expected no transfer", bus.xfer_addr);
                    end else chk("xfer_dir_addr_len", 96'({bus.xfer_dir, bus.xfer_addr, bus.xfer_len}),
                                 96'(exp_xfer_q.pop_front()));
                end
                if (dma_int)       begin n_int++;  chk_evt("evt_dma_int", EV_INT);  end
                if (xfer_complete) begin n_cmpl++; chk_evt("evt_complete", EV_CMPL); end
                if (gap_evt)       begin n_gap++;  chk_evt("evt_gap", EV_GAP);      end
                if (adma_err)      begin n_err++;  chk_evt("evt_adma_err", EV_ERR); end
            end
            prev_dreq = bus.desc_req; prev_xreq = bus.xfer_req;
        end
    end

    // Driver tasks
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 4000) begin @(negedge clk); n++; end
        chk({tag, "_idle_timeout"}, 96'(busy), 96'(0));
    endtask

    task automatic begin_chain(input string tag, input logic [63:0] base, input logic d,
                               input int errx, input logic [7:0] gmask, input logic gap_lvl);
        fetch_log.delete();
        n_int = 0; n_cmpl = 0; n_gap = 0; n_err = 0; n_xfer = 0;
        xfer_count = 0; err_xfer = errx;
        model_chain(base, d, errx, gmask);
        stop_at_gap = gap_lvl;
        @(negedge clk);
        start = 1'b1; init_addr = base; dir = d;
        @(negedge clk);
        start = 1'b0;
        wait_idle(tag);
    endtask

    task automatic finish_chain(input string tag);
        for (int k = 0; k < 8 && paused; k++) begin
            stop_at_gap = 1'b0;
            continue_req = 1'b1;
            @(negedge clk);
            continue_req = 1'b0;
            wait_idle(tag);
        end
        chk({tag, "_err_state"}, 96'(err_state), 96'(exp_err_g));
        chk({tag, "_fetch_left"}, 96'(exp_fetch_q.size()), 96'(0));
        chk({tag, "_xfer_left"}, 96'(exp_xfer_q.size()), 96'(0));
        chk({tag, "_evt_left"}, 96'(exp_evt_q.size()), 96'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; stop_at_gap = 1'b0; continue_req = 1'b0;
        init_addr = '0; chk_en = 1'b1; xfer_hold = 1'b0; err_xfer = -1; xfer_count = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_desc_req", 96'(bus.desc_req), 96'(0));
        chk("rst_xfer_req", 96'(bus.xfer_req), 96'(0));
        chk("rst_sys_adr", 96'(sys_adr), 96'(0));
        chk("rst_xfer_len", 96'(bus.xfer_len), 96'(0));
        chk("rst_err_state", 96'(err_state), 96'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single TRAN End=1
        mem.delete();
        mem[64'h8000] = mk_desc(1, 1, 0, ACT_TRAN, 16'h0200, 64'h1000);
        begin_chain("t1", 64'h8000, 1'b0, -1, 8'h00, 1'b0);
        finish_chain("t1");
        chk("t1_len_512", 96'(last_xfer_len), 96'(512));
        chk("t1_sys_adr", 96'(sys_adr), 96'(64'h800C));
        chk("t1_complete_cnt", 96'(n_cmpl), 96'(1));

        // 2: NOP, LINK->0x9000, TRAN Len=0 End Int
        mem.delete();
        mem[64'h8000] = mk_desc(1, 0, 0, ACT_NOP, 16'h0000, 64'h0);
        mem[64'h800C] = mk_desc(1, 0, 0, ACT_LINK, 16'h0000, 64'h9000);
        mem[64'h9000] = mk_desc(1, 1, 1, ACT_TRAN, 16'h0000, 64'h2000);
        begin_chain("t2", 64'h8000, 1'b0, -1, 8'h00, 1'b0);
        finish_chain("t2");
        chk("t2_fetch_cnt", 96'(fetch_log.size()), 96'(3));
        if (fetch_log.size() == 3) begin
            chk("t2_fetch0", 96'(fetch_log[0]), 96'(64'h8000));
            chk("t2_fetch1", 96'(fetch_log[1]), 96'(64'h800C));
            chk("t2_fetch2", 96'(fetch_log[2]), 96'(64'h9000));
        end
        chk("t2_len_64k", 96'(last_xfer_len), 96'(65536));
        chk("t2_int_cnt", 96'(n_int), 96'(1));

        // 3a: Valid=0 at second descriptor
        mem.delete();
        mem[64'h8000] = mk_desc(1, 0, 0, ACT_NOP, 16'h0000, 64'h0);
        mem[64'h800C] = mk_desc(0, 1, 0, ACT_TRAN, 16'h0100, 64'h5000);
        begin_chain("t3a", 64'h8000, 1'b0, -1, 8'h00, 1'b0);
        finish_chain("t3a");
        chk("t3a_err_01", 96'(err_state), 96'(2'b01));
        chk("t3a_no_xfer", 96'(n_xfer), 96'(0));
        chk("t3a_err_pulse", 96'(n_err), 96'(1));

        // 3b: transfer error
        mem.delete();
        mem[64'h8000] = mk_desc(1, 0, 1, ACT_TRAN, 16'h0040, 64'h3000);
        begin_chain("t3b", 64'h8000, 1'b1, 0, 8'h00, 1'b0);
        finish_chain("t3b");
        chk("t3b_err_11", 96'(err_state), 96'(2'b11));

        // 4: three TRANs, block-gap stop after the first
        mem.delete();
        mem[64'h8000] = mk_desc(1, 0, 0, ACT_TRAN, 16'h0010, 64'h0100);
        mem[64'h800C] = mk_desc(1, 0, 0, ACT_TRAN, 16'h0020, 64'h0200);
        mem[64'h8018] = mk_desc(1, 1, 1, ACT_TRAN, 16'h0030, 64'h0300);
        begin_chain("t4", 64'h8000, 1'b1, -1, 8'h01, 1'b1);
        chk("t4_paused", 96'(paused), 96'(1));
        chk("t4_gap_cnt", 96'(n_gap), 96'(1));
        chk("t4_sys_adr_gap", 96'(sys_adr), 96'(64'h800C));
        finish_chain("t4");
        chk("t4_paused_clr", 96'(paused), 96'(0));
        chk("t4_fetch_cnt", 96'(fetch_log.size()), 96'(3));
        if (fetch_log.size() > 1) chk("t4_resume_addr", 96'(fetch_log[1]), 96'(64'h800C));

        // 5: LINK to itself -> chain-loop error after 16 fetches
        mem.delete();
        mem[64'h8000] = mk_desc(1, 0, 0, ACT_LINK, 16'h0000, 64'h8000);
        begin_chain("t5", 64'h8000, 1'b0, -1, 8'h00, 1'b0);
        finish_chain("t5");
        chk("t5_fetch_16", 96'(fetch_log.size()), 96'(16));
        chk("t5_err_01", 96'(err_state), 96'(2'b01));

        // 6: reset in the middle of a transfer, then a clean chain
        mem.delete();
        mem[64'h8000] = mk_desc(1, 1, 0, ACT_TRAN, 16'h0080, 64'h4000);
        chk_en = 1'b0; xfer_hold = 1'b1;
        @(negedge clk); start = 1'b1; init_addr = 64'h8000; dir = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 200 && !bus.xfer_req; n++) @(negedge clk);
        chk("t6_reach_tfr", 96'(bus.xfer_req), 96'(1));
        #3 rst_n = 1'b0;
        #1;
        chk("t6_xfer_req_drop", 96'(bus.xfer_req), 96'(0));
        chk("t6_desc_req_drop", 96'(bus.desc_req), 96'(0));
        chk("t6_busy_drop", 96'(busy), 96'(0));
        chk("t6_sys_adr_clr", 96'(sys_adr), 96'(0));
        chk("t6_xfer_addr_clr", 96'(bus.xfer_addr), 96'(0));
        chk("t6_xfer_len_clr", 96'(bus.xfer_len), 96'(0));
        @(negedge clk); rst_n = 1'b1; xfer_hold = 1'b0;
        exp_fetch_q.delete(); exp_xfer_q.delete(); exp_evt_q.delete();
        @(negedge clk); chk_en = 1'b1;
        begin_chain("t6", 64'h8000, 1'b1, -1, 8'h00, 1'b0);
        finish_chain("t6");
        chk("t6_len_128", 96'(last_xfer_len), 96'(128));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end
endmodule
